// File: rtl/fwrisc_operand_fetch.sv
`default_nettype none
//============================================================================
// Module      : fwrisc_operand_fetch
// Description : Operand-fetch stage between the decoder and the 64-entry
//               register file. Accepts rs1/rs2 requests over valid/ready,
//               drives the regfile read ports (address registered one cycle
//               before data), captures both operands, forwards snooped
//               writes so held operands never go stale, and presents the
//               operands to execute over valid/ready.
//
// Ports       : i_clock, i_reset          - clock, async active-high reset
//               i_flush                   - drop in-flight / held request
//               i_req_valid/o_req_ready   - request handshake
//               i_req_rs1/i_req_rs2       - source addresses
//               o_ra_raddr/i_ra_rdata     - regfile read port A
//               o_rb_raddr/i_rb_rdata     - regfile read port B
//               i_rd_waddr/i_rd_wdata/i_rd_wen - snooped regfile write
//               o_out_valid/i_out_ready   - operand handshake
//               o_out_op_a/o_out_op_b     - operands
//
// Revision    : 1.0 - initial release
//============================================================================
module fwrisc_operand_fetch #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_rs1,
    input  logic [ADDR_W-1:0] i_req_rs2,
    output logic [ADDR_W-1:0] o_ra_raddr,
    input  logic [DATA_W-1:0] i_ra_rdata,
    output logic [ADDR_W-1:0] o_rb_raddr,
    input  logic [DATA_W-1:0] i_rb_rdata,
    input  logic [ADDR_W-1:0] i_rd_waddr,
    input  logic [DATA_W-1:0] i_rd_wdata,
    input  logic              i_rd_wen,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_op_a,
    output logic [DATA_W-1:0] o_out_op_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;

    logic              w_req_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_fwd_a;
    logic              w_fwd_b;

    // A write matching a held address; address 0 is hardwired zero and
    // is never forwarded.
    assign w_fwd_a = i_rd_wen && (i_rd_waddr != c_ZERO_ADDR) && (i_rd_waddr == r_rs1);
    assign w_fwd_b = i_rd_wen && (i_rd_waddr != c_ZERO_ADDR) && (i_rd_waddr == r_rs2);

    // Value captured at the end of the READ cycle. The regfile data already
    // reflects writes up to the previous cycle; only a write landing in the
    // READ cycle itself needs forwarding.
    assign w_rd_a = (r_rs1 == c_ZERO_ADDR) ? '0 : (w_fwd_a ? i_rd_wdata : i_ra_rdata);
    assign w_rd_b = (r_rs2 == c_ZERO_ADDR) ? '0 : (w_fwd_b ? i_rd_wdata : i_rb_rdata);

    always_comb begin
        w_req_ready = 1'b0;
        w_state_nxt = r_state;
        if (!i_flush) begin
            w_req_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && i_out_ready);
        end
        w_accept = i_req_valid && w_req_ready;

        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_nxt = S_READ;
                S_READ: w_state_nxt = S_OUT;
                S_OUT: begin
                    if (i_out_ready) begin
                        w_state_nxt = w_accept ? S_READ : S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
        end else if (w_accept) begin
            r_rs1 <= i_req_rs1;
            r_rs2 <= i_req_rs2;
        end
    end

    // Operand registers: load in READ, then track writes while held in OUT.
    // A consume coinciding with a write hands over the pre-write value; the
    // update afterwards is harmless since the register is reloaded or idle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    r_op_a <= w_rd_a;
                    r_op_b <= w_rd_b;
                end
                S_OUT: begin
                    if (w_fwd_a) r_op_a <= i_rd_wdata;
                    if (w_fwd_b) r_op_b <= i_rd_wdata;
                end
                default: ;
            endcase
        end
    end

    // The regfile registers its address, so a new request's addresses go
    // straight through in the accept cycle; otherwise keep presenting the
    // held addresses.
    assign o_ra_raddr  = w_accept ? i_req_rs1 : r_rs1;
    assign o_rb_raddr  = w_accept ? i_req_rs2 : r_rs2;
    assign o_req_ready = w_req_ready;
    assign o_out_valid = (r_state == S_OUT);
    assign o_out_op_a  = r_op_a;
    assign o_out_op_b  = r_op_b;

endmodule
`default_nettype wire
